// File: rtl/noc_pkg.sv
// Shared packet layout and TX state encoding for the neuron-core
// network interface.
package noc_pkg;

  localparam int PACKET_WIDTH = 32;

  localparam int DEST_MSB   = 31;
  localparam int DEST_LSB   = 28;
  localparam int SRC_MSB    = 27;
  localparam int SRC_LSB    = 24;
  localparam int NEURON_MSB = 23;
  localparam int NEURON_LSB = 16;
  localparam int TS_MSB     = 15;
  localparam int TS_LSB     = 0;

  localparam int ADDR_FLD_W = DEST_MSB - DEST_LSB + 1;
  localparam int NRN_FLD_W  = NEURON_MSB - NEURON_LSB + 1;
  localparam int TS_WIDTH   = TS_MSB - TS_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO; a push while full is refused even if a pop
// happens on the same edge.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/noc_network_interface.sv
// Network interface between a neuron core and a mesh router local
// port: spike-to-packet TX with destination table, filtered RX.
module noc_network_interface
  import noc_pkg::*;
#(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int NEURON_ID_WIDTH   = 8,
  parameter int TX_FIFO_DEPTH     = 4,
  parameter int RX_FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROUTER_ADDR_WIDTH-1:0] router_addr,
  input  logic [15:0]                  current_timestep,
  input  logic [NEURON_ID_WIDTH-1:0]   spike_in_neuron_id,
  input  logic                         spike_in_valid,
  output logic                         spike_in_ready,
  output logic [31:0]                  net_tx_packet,
  output logic                         net_tx_valid,
  input  logic                         net_tx_ready,
  input  logic [31:0]                  net_rx_packet,
  input  logic                         net_rx_valid,
  output logic                         net_rx_ready,
  output logic [ROUTER_ADDR_WIDTH-1:0] spike_out_src_addr,
  output logic [NEURON_ID_WIDTH-1:0]   spike_out_src_neuron,
  output logic [15:0]                  spike_out_timestep,
  output logic                         spike_out_valid,
  input  logic                         spike_out_ready,
  input  logic                         cfg_we,
  input  logic [NEURON_ID_WIDTH-1:0]   cfg_neuron_id,
  input  logic [ROUTER_ADDR_WIDTH-1:0] cfg_dest_addr,
  input  logic                         cfg_dest_en,
  output logic [15:0]                  tx_count,
  output logic [15:0]                  rx_count,
  output logic [15:0]                  drop_count
);

  localparam int RAW = ROUTER_ADDR_WIDTH;
  localparam int NID = NEURON_ID_WIDTH;
  localparam int TBL = 1 << NID;
  localparam int TXW = NID + TS_WIDTH;
  localparam int RXW = RAW + NID + TS_WIDTH;

  // destination table
  logic           en_q   [TBL];
  logic [RAW-1:0] dest_q [TBL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL; i++) begin
        en_q[i]   <= 1'b0;
        dest_q[i] <= '0;
      end
    end else if (cfg_we) begin
      en_q[cfg_neuron_id]   <= cfg_dest_en;
      dest_q[cfg_neuron_id] <= cfg_dest_addr;
    end
  end

  // TX path
  logic           tx_push, tx_pop;
  logic           tx_full, tx_empty;
  logic [TXW-1:0] tx_dout;

  assign spike_in_ready = !tx_full;
  assign tx_push = spike_in_valid && !tx_full;

  noc_sync_fifo #(
    .WIDTH (TXW),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .data_i  ({spike_in_neuron_id, current_timestep}),
    .pop_i   (tx_pop),
    .data_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  tx_state_e              state_q, state_d;
  logic [TXW-1:0]         hold_q, hold_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic [PACKET_WIDTH-1:0] pkt_build;
  logic [NID-1:0]         hold_nid;
  logic [TS_WIDTH-1:0]    hold_ts;
  logic                   tx_inc;
  logic                   tx_drop;

  assign hold_nid = hold_q[TS_WIDTH +: NID];
  assign hold_ts  = hold_q[TS_WIDTH-1:0];

  always_comb begin
    pkt_build = '0;
    pkt_build[DEST_LSB +: RAW]     = dest_q[hold_nid];
    pkt_build[SRC_LSB +: RAW]      = router_addr;
    pkt_build[NEURON_LSB +: NID]   = hold_nid;
    pkt_build[TS_MSB:TS_LSB]       = hold_ts;
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    pkt_d        = pkt_q;
    tx_pop       = 1'b0;
    tx_inc       = 1'b0;
    tx_drop      = 1'b0;
    net_tx_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          hold_d  = tx_dout;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (en_q[hold_nid]) begin
          pkt_d   = pkt_build;
          state_d = SEND;
        end else begin
          tx_drop = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        net_tx_valid = 1'b1;
        if (net_tx_ready) begin
          tx_inc  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pkt_q   <= pkt_d;
    end
  end

  assign net_tx_packet = pkt_q;

  // RX path
  logic [ADDR_FLD_W-1:0] addr_ext;
  logic [ADDR_FLD_W-1:0] rx_src_fld;
  logic [NRN_FLD_W-1:0]  rx_nrn_fld;
  logic                  rx_full, rx_empty;
  logic                  rx_acc, rx_hit;
  logic                  rx_push, rx_drop;
  logic [RXW-1:0]        rx_din, rx_dout;

  always_comb begin
    addr_ext = '0;
    addr_ext[RAW-1:0] = router_addr;
  end

  assign rx_src_fld   = net_rx_packet[SRC_MSB:SRC_LSB];
  assign rx_nrn_fld   = net_rx_packet[NEURON_MSB:NEURON_LSB];
  assign rx_hit       = (net_rx_packet[DEST_MSB:DEST_LSB] == addr_ext);
  assign net_rx_ready = !rx_full;
  assign rx_acc       = net_rx_valid && !rx_full;
  assign rx_push      = rx_acc && rx_hit;
  assign rx_drop      = rx_acc && !rx_hit;
  assign rx_din       = {rx_src_fld[RAW-1:0], rx_nrn_fld[NID-1:0],
                         net_rx_packet[TS_MSB:TS_LSB]};

  noc_sync_fifo #(
    .WIDTH (RXW),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .data_i  (rx_din),
    .pop_i   (spike_out_ready),
    .data_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // stale FIFO contents stay hidden while nothing is queued
  always_comb begin
    spike_out_valid      = !rx_empty;
    spike_out_src_addr   = '0;
    spike_out_src_neuron = '0;
    spike_out_timestep   = '0;
    if (!rx_empty) begin
      spike_out_src_addr   = rx_dout[NID+TS_WIDTH +: RAW];
      spike_out_src_neuron = rx_dout[TS_WIDTH +: NID];
      spike_out_timestep   = rx_dout[TS_WIDTH-1:0];
    end
  end

  // statistics
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    tx_cnt_d   = tx_cnt_q + {15'd0, tx_inc};
    rx_cnt_d   = rx_cnt_q + {15'd0, rx_push};
    drop_cnt_d = drop_cnt_q + {15'd0, tx_drop} + {15'd0, rx_drop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_count   = tx_cnt_q;
  assign rx_count   = rx_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule
